// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - RV32I-subset opcodes, function codes, ALU/immediate enums and immediate generator
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_t t);
    case (t)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - 32x32 register file, two async read ports, one write port, x0 reads zero
module cpu_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - single-cycle RV32I-subset core; CPU_MUL_EN adds single-cycle MUL
module cpu_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] INSTR,
  input  logic [WIDTH-1:0] READ_MEM_DATA,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] MEM_ADDR,
  output logic             WRITE_MEM_EN,
  output logic [WIDTH-1:0] WRITE_MEM_DATA
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = INSTR[6:0];
  assign rd     = INSTR[11:7];
  assign funct3 = INSTR[14:12];
  assign rs1    = INSTR[19:15];
  assign rs2    = INSTR[24:20];
  assign funct7 = INSTR[31:25];

  alu_op_t          alu_op;
  imm_t             imm_sel;
  wb_sel_t          wb_sel;
  logic             use_imm, reg_we, mem_we, is_branch, is_jal, is_jalr;
  logic [WIDTH-1:0] rs1_val, rs2_val, imm, alu_b, alu_result, wb_data, pc_plus4, next_pc;
  logic             branch_taken;

  always_comb begin
    alu_op    = ALU_ADD;
    imm_sel   = IMM_I;
    wb_sel    = WB_ALU;
    use_imm   = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_R: begin
        reg_we = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  alu_op = ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          alu_op = ALU_SRA;
`ifdef CPU_MUL_EN
        end else if (funct7 == F7_MUL && funct3 == F3_ADD) begin
          alu_op = ALU_MUL;
`endif
        end else begin
          reg_we = 1'b0;
        end
      end
      OP_I: begin
        use_imm = 1'b1;
        reg_we  = 1'b1;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLT:  alu_op = ALU_SLT;
          F3_XOR:  alu_op = ALU_XOR;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          default: reg_we = 1'b0;
        endcase
      end
      OP_LOAD: begin
        use_imm = 1'b1;
        wb_sel  = WB_MEM;
        reg_we  = (funct3 == F3_W);
      end
      OP_STORE: begin
        use_imm = 1'b1;
        imm_sel = IMM_S;
        mem_we  = (funct3 == F3_W);
      end
      OP_BRANCH: begin
        imm_sel   = IMM_B;
        alu_op    = ALU_SUB;
        is_branch = (funct3 == F3_BEQ) || (funct3 == F3_BNE) || (funct3 == F3_BLT);
      end
      OP_JAL: begin
        imm_sel = IMM_J;
        wb_sel  = WB_PC4;
        reg_we  = 1'b1;
        is_jal  = 1'b1;
      end
      OP_JALR: begin
        use_imm = 1'b1;
        wb_sel  = WB_PC4;
        reg_we  = (funct3 == 3'b000);
        is_jalr = (funct3 == 3'b000);
      end
      OP_LUI: begin
        imm_sel = IMM_U;
        use_imm = 1'b1;
        alu_op  = ALU_PASS_B;
        reg_we  = 1'b1;
      end
      default: ;
    endcase
  end

  cpu_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk    (CLK),
    .rst_n  (RESET),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .we     (reg_we),
    .waddr  (rd),
    .wdata  (wb_data)
  );

  assign imm   = imm_gen(INSTR, imm_sel);
  assign alu_b = use_imm ? imm : rs2_val;

  always_comb begin
    alu_result = rs1_val + alu_b;
    case (alu_op)
      ALU_SUB:    alu_result = rs1_val - alu_b;
      ALU_AND:    alu_result = rs1_val & alu_b;
      ALU_OR:     alu_result = rs1_val | alu_b;
      ALU_XOR:    alu_result = rs1_val ^ alu_b;
      ALU_SLT:    alu_result = {{(WIDTH-1){1'b0}}, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLL:    alu_result = rs1_val << alu_b[4:0];
      ALU_SRL:    alu_result = rs1_val >> alu_b[4:0];
      ALU_SRA:    alu_result = $signed(rs1_val) >>> alu_b[4:0];
`ifdef CPU_MUL_EN
      ALU_MUL:    alu_result = rs1_val * alu_b;
`endif
      ALU_PASS_B: alu_result = alu_b;
      default:    ;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_BEQ:  branch_taken = (rs1_val == rs2_val);
      F3_BNE:  branch_taken = (rs1_val != rs2_val);
      default: branch_taken = ($signed(rs1_val) < $signed(rs2_val));
    endcase
  end

  assign pc_plus4 = PC + 32'd4;

  always_comb begin
    if (is_jalr)                             next_pc = alu_result & ~32'd1;
    else if (is_jal || (is_branch && branch_taken)) next_pc = PC + imm;
    else                                     next_pc = pc_plus4;
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = READ_MEM_DATA;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_result;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) PC <= '0;
    else        PC <= next_pc;
  end

  // Store strobe is gated by reset so the RAM can never be written while held in reset.
  assign WRITE_MEM_EN   = mem_we & RESET;
  assign MEM_ADDR       = alu_result;
  assign WRITE_MEM_DATA = rs2_val;

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - table-driven scoreboard bench for cpu_core
module tb_cpu_core;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTR = 32'h0;
  logic [31:0] READ_MEM_DATA = 32'h0;
  logic [31:0] PC, MEM_ADDR, WRITE_MEM_DATA;
  logic        WRITE_MEM_EN;

  cpu_core dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .INSTR          (INSTR),
    .READ_MEM_DATA  (READ_MEM_DATA),
    .PC             (PC),
    .MEM_ADDR       (MEM_ADDR),
    .WRITE_MEM_EN   (WRITE_MEM_EN),
    .WRITE_MEM_DATA (WRITE_MEM_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        chk_addr;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t prog[$];
  vec_t prog2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], ST};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BR};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JL};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic ca,
                              input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input logic [31:0] rdata);
    vec_t v;
    v.instr = instr; v.pc = pc; v.chk_addr = ca; v.addr = addr;
    v.we = we; v.wdata = wdata; v.rdata = rdata;
    return v;
  endfunction

  // Drive one instruction, queue its expectation, compare at the falling edge, then let it retire.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    INSTR = v.instr;
    READ_MEM_DATA = v.rdata;
    sb.push_back(v);
    @(negedge CLK);
    e = sb.pop_front();
    chk($sformatf("v%0d pc", idx), PC, e.pc);
    chk($sformatf("v%0d we", idx), {31'b0, WRITE_MEM_EN}, {31'b0, e.we});
    if (e.chk_addr) chk($sformatf("v%0d mem_addr", idx), MEM_ADDR, e.addr);
    if (e.we) chk($sformatf("v%0d wdata", idx), WRITE_MEM_DATA, e.wdata);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    prog.push_back(mk(enc_i(5, 0, 3'b000, 1, I),        32'h00, 1, 32'h5,        0, 0, 0));
    prog.push_back(mk(enc_i(-3, 0, 3'b000, 2, I),       32'h04, 1, 32'hFFFFFFFD, 0, 0, 0));
    prog.push_back(mk(enc_r(7'h00, 2, 1, 3'b000, 3),    32'h08, 1, 32'h2,        0, 0, 0));
    prog.push_back(mk(enc_r(7'h20, 2, 1, 3'b000, 4),    32'h0C, 1, 32'h8,        0, 0, 0));
    prog.push_back(mk(enc_r(7'h00, 1, 2, 3'b010, 5),    32'h10, 1, 32'h1,        0, 0, 0));
    prog.push_back(mk(enc_i(7, 0, 3'b000, 0, I),        32'h14, 1, 32'h7,        0, 0, 0));
    prog.push_back(mk(enc_i(0, 0, 3'b000, 6, I),        32'h18, 1, 32'h0,        0, 0, 0));
    prog.push_back(mk(enc_s(0, 3, 0),                   32'h1C, 1, 32'h0,        1, 32'h2, 0));
    prog.push_back(mk(enc_s(0, 4, 0),                   32'h20, 1, 32'h0,        1, 32'h8, 0));
    prog.push_back(mk(enc_s(0, 5, 0),                   32'h24, 1, 32'h0,        1, 32'h1, 0));
    prog.push_back(mk(enc_i(32'h40, 0, 3'b000, 1, I),   32'h28, 1, 32'h40,       0, 0, 0));
    prog.push_back(mk({20'h00001, 5'd2, LU},            32'h2C, 1, 32'h1000,     0, 0, 0));
    prog.push_back(mk(enc_i(32'h234, 2, 3'b000, 2, I),  32'h30, 1, 32'h1234,     0, 0, 0));
    prog.push_back(mk(enc_s(4, 2, 1),                   32'h34, 1, 32'h44,       1, 32'h1234, 0));
    prog.push_back(mk(enc_i(4, 1, 3'b010, 3, LD),       32'h38, 1, 32'h44,       0, 0, 32'h1234));
    prog.push_back(mk(enc_i(0, 3, 3'b000, 0, I),        32'h3C, 1, 32'h1234,     0, 0, 0));
    prog.push_back(mk(enc_b(8, 0, 0, 3'b000),           32'h40, 0, 0,            0, 0, 0));
    prog.push_back(mk(enc_b(8, 0, 0, 3'b001),           32'h48, 0, 0,            0, 0, 0));
    prog.push_back(mk(enc_j(-16, 1),                    32'h4C, 0, 0,            0, 0, 0));
    prog.push_back(mk(enc_i(0, 1, 3'b000, 0, JR),       32'h3C, 1, 32'h50,       0, 0, 0));
    prog.push_back(mk(enc_b(12, 1, 2, 3'b100),          32'h50, 0, 0,            0, 0, 0));
    prog.push_back(mk(enc_b(12, 2, 1, 3'b100),          32'h54, 0, 0,            0, 0, 0));
    prog.push_back(mk(enc_i(3, 1, 3'b000, 5, JR),       32'h60, 1, 32'h53,       0, 0, 0));
    prog.push_back(mk(enc_i(0, 5, 3'b000, 0, I),        32'h52, 1, 32'h64,       0, 0, 0));
    prog.push_back(mk({20'h80000, 5'd1, LU},            32'h56, 1, 32'h80000000, 0, 0, 0));
    prog.push_back(mk(enc_i(-1, 1, 3'b000, 2, I),       32'h5A, 1, 32'h7FFFFFFF, 0, 0, 0));
    prog.push_back(mk(enc_s(0, 2, 0),                   32'h5E, 1, 32'h0,        1, 32'h7FFFFFFF, 0));
    prog.push_back(mk(32'hFFFFFFFF,                     32'h62, 0, 0,            0, 0, 0));
    prog.push_back(mk(enc_s(0, 31, 0),                  32'h66, 1, 32'h0,        1, 32'h0, 0));
    prog.push_back(mk(enc_i(7, 0, 3'b000, 8, I),        32'h6A, 1, 32'h7,        0, 0, 0));
    prog.push_back(mk(enc_i(-2, 0, 3'b000, 9, I),       32'h6E, 1, 32'hFFFFFFFE, 0, 0, 0));
`ifdef CPU_MUL_EN
    prog.push_back(mk(enc_r(7'h01, 9, 8, 3'b000, 10),   32'h72, 1, 32'hFFFFFFF2, 0, 0, 0));
    prog.push_back(mk(enc_s(0, 10, 0),                  32'h76, 1, 32'h0,        1, 32'hFFFFFFF2, 0));
`else
    prog.push_back(mk(enc_r(7'h01, 9, 8, 3'b000, 10),   32'h72, 0, 0,            0, 0, 0));
    prog.push_back(mk(enc_s(0, 10, 0),                  32'h76, 1, 32'h0,        1, 32'h0, 0));
`endif
    prog.push_back(mk(enc_r(7'h00, 9, 8, 3'b100, 0),    32'h7A, 1, 32'hFFFFFFF9, 0, 0, 0));
    prog.push_back(mk(enc_r(7'h20, 8, 9, 3'b101, 0),    32'h7E, 1, 32'hFFFFFFFF, 0, 0, 0));
    prog.push_back(mk(enc_r(7'h00, 8, 9, 3'b101, 0),    32'h82, 1, 32'h01FFFFFF, 0, 0, 0));
    prog.push_back(mk(enc_r(7'h00, 8, 8, 3'b001, 0),    32'h86, 1, 32'h380,      0, 0, 0));
    prog.push_back(mk(enc_r(7'h00, 9, 8, 3'b111, 0),    32'h8A, 1, 32'h6,        0, 0, 0));
    prog.push_back(mk(enc_r(7'h00, 9, 8, 3'b110, 0),    32'h8E, 1, 32'hFFFFFFFF, 0, 0, 0));
    prog.push_back(mk(enc_i(0, 9, 3'b010, 0, I),        32'h92, 1, 32'h1,        0, 0, 0));
    prog.push_back(mk(enc_i(-4, 0, 3'b000, 1, I),       32'h96, 1, 32'hFFFFFFFC, 0, 0, 0));
    prog.push_back(mk(enc_i(0, 1, 3'b000, 0, JR),       32'h9A, 1, 32'hFFFFFFFC, 0, 0, 0));
    prog.push_back(mk(enc_i(0, 0, 3'b000, 0, I),        32'hFFFFFFFC, 1, 32'h0,  0, 0, 0));
    prog.push_back(mk(enc_i(1, 0, 3'b000, 0, I),        32'h00, 1, 32'h1,        0, 0, 0));

    prog2.push_back(mk(enc_s(0, 2, 0),                  32'h00, 1, 32'h0,        1, 32'h0, 0));
    prog2.push_back(mk(enc_s(0, 9, 0),                  32'h04, 1, 32'h0,        1, 32'h0, 0));
    prog2.push_back(mk(enc_i(0, 5, 3'b000, 0, I),       32'h08, 1, 32'h0,        0, 0, 0));

    // Reset held for 100 ns with a store on the bus: the strobe must stay low.
    INSTR = enc_s(0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk($sformatf("reset%0d pc", c), PC, 32'h0);
      chk($sformatf("reset%0d we", c), {31'b0, WRITE_MEM_EN}, 32'h0);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    for (int k = 0; k < prog.size(); k++) run_vec(prog[k], k);

    // Asynchronous reset between clock edges clears PC without waiting for a clock.
    INSTR = enc_s(0, 2, 0);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_reset pc", PC, 32'h0);
    chk("async_reset we", {31'b0, WRITE_MEM_EN}, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    for (int k = 0; k < prog2.size(); k++) run_vec(prog2[k], 100 + k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
